// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side signals of the data memory arbiter.
// The arbiter connects through the slave modport; the requesters and the
// memory model sit on the master side.
interface dmem_arbiter_if;
    // port 0 (CPU load/store stage)
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        ack0;
    logic        err0;
    logic [31:0] rdata0;

    // port 1 (DMA/debug engine)
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ack1;
    logic        err1;
    logic [31:0] rdata1;

    // single-port data memory
    logic [5:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, err0, rdata0,
        output ack1, err1, rdata1,
        output mem_op, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, err0, rdata0,
        input  ack1, err1, rdata1,
        input  mem_op, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port data
// memory. Every output is registered; the ACCESS phase lasts WAIT_CYCLES+1
// cycles and a store drives its write opcode only on the last of them.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transaction; sample requests and grant one port
// ACCESS | memory opcode/address driven, cnt counts remaining wait cycles
// ACK    | one-cycle ack (and err) pulse to the granted port
module dmem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [5:0]  OP_LW       = 6'h23,
    parameter logic [5:0]  OP_SW       = 6'h2B
) (
    input  logic            clock,
    input  logic            reset_n,
    dmem_arbiter_if.slave   bus
);

    localparam logic [5:0] OP_IDLE  = 6'h00;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        gnt;          // port owning the current transaction
    logic        we_q;         // latched store flag of the granted request
    logic        last_grant;   // port granted most recently, for tie-breaks

    logic        pick;
    logic        pick_we;
    logic [31:0] pick_addr;
    logic [31:0] pick_wdata;
    logic        pick_misaligned;

    // Arbitration choice: a lone request wins, a tie goes to the port not granted last.
    always_comb begin
        pick = bus.req1;
        if (bus.req0 && bus.req1) begin
            pick = ~last_grant;
        end
        pick_we         = pick ? bus.we1    : bus.we0;
        pick_addr       = pick ? bus.addr1  : bus.addr0;
        pick_wdata      = pick ? bus.wdata1 : bus.wdata0;
        pick_misaligned = (pick_addr[1:0] != 2'b00);
    end

    // Sequencer FSM with registered memory drive, acks and read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            gnt           <= 1'b0;
            we_q          <= 1'b0;
            last_grant    <= 1'b1;
            bus.mem_op    <= OP_IDLE;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.err0      <= 1'b0;
            bus.err1      <= 1'b0;
            bus.rdata0    <= 32'd0;
            bus.rdata1    <= 32'd0;
            bus.busy      <= 1'b0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.err0 <= 1'b0;
            bus.err1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gnt           <= pick;
                        last_grant    <= pick;
                        we_q          <= pick_we;
                        bus.mem_addr  <= pick_addr;
                        bus.mem_wdata <= pick_wdata;
                        bus.busy      <= 1'b1;
                        if (pick_misaligned) begin
                            // rejected without touching memory
                            state      <= ACK;
                            cnt        <= 4'd0;
                            bus.mem_op <= OP_IDLE;
                            bus.ack0   <= ~pick;
                            bus.ack1   <= pick;
                            bus.err0   <= ~pick;
                            bus.err1   <= pick;
                        end else begin
                            state <= ACCESS;
                            cnt   <= CNT_LOAD;
                            if (!pick_we) begin
                                bus.mem_op <= OP_LW;
                            end else if (CNT_LOAD == 4'd0) begin
                                bus.mem_op <= OP_SW;
                            end else begin
                                bus.mem_op <= OP_IDLE;
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        // a store writes only in the final ACCESS cycle
                        if (we_q && (cnt == 4'd1)) begin
                            bus.mem_op <= OP_SW;
                        end
                    end else begin
                        state      <= ACK;
                        bus.mem_op <= OP_IDLE;
                        bus.ack0   <= ~gnt;
                        bus.ack1   <= gnt;
                        if (!we_q) begin
                            if (gnt) begin
                                bus.rdata1 <= bus.mem_rdata;
                            end else begin
                                bus.rdata0 <= bus.mem_rdata;
                            end
                        end
                    end
                end

                ACK: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    cnt        <= 4'd0;
                    bus.mem_op <= OP_IDLE;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory. It shares the memory between the CPU load/store stage (port 0) and a DMA/debug engine (port 1) using round-robin arbitration. It drives the memory's opcode, address and write-data inputs with a configurable number of wait cycles, and returns read data and a completion pulse to the granted requester.

## Interface
- WAIT_CYCLES, 1, extra memory cycles per access (0..15); the ACCESS phase lasts WAIT_CYCLES+1 cycles.
- OP_LW, 6'h23, opcode driven for a load.
- OP_SW, 6'h2B, opcode driven for a store.
- clock  in  1  sole clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; held with its qualifiers until the matching ack.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  32  store data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  misalignment flag, valid only with the ack.
- rdata0 / rdata1  out  32  load result, held until the next load ack to that port.
- mem_op  out  6  OP_LW, OP_SW or 6'h00 (idle).
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational read data from memory.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any req is high, grant one port, latch its we/addr/wdata, load cnt=WAIT_CYCLES, go to ACCESS. A misaligned request (addr[1:0]!=0) goes to ACK with err set and no memory operation.
  - ACCESS: if cnt>0, decrement cnt; if cnt==0, go to ACK.
  - ACK: pulse ack and err for the granted port, then go to IDLE.
- Arbitration:
  - A single request wins outright.
  - With both requests high, the port not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
- Memory drive:
  - Load: mem_op=OP_LW for every ACCESS cycle. mem_rdata is captured into the granted port's rdata at the final ACCESS edge (cnt==0).
  - Store: mem_op=OP_SW only on the final ACCESS cycle, so exactly one write edge occurs. Earlier ACCESS cycles drive 6'h00.
  - Outside ACCESS, mem_op=6'h00.
  - mem_addr and mem_wdata hold the latched values from grant until the next grant.
- rdata of the non-granted port never changes. A store does not modify rdata.
- Requester misbehaviour: if req drops before ack, the transaction still completes and acks. A new req in the ACK cycle is not sampled until IDLE.
- Reset, asynchronous and also mid-transaction:
  - State goes to IDLE and cnt to 0.
  - mem_op=6'h00, mem_addr=0, mem_wdata=0.
  - ack0/1=0, err0/1=0, rdata0/1=0, busy=0, last_grant=1.
  - An aborted store issues no write.

## Timing
- All outputs are registered. No combinational path exists from req or mem_rdata to any output.
- Latency: with req first high in cycle t, ack is high in cycle t+WAIT_CYCLES+2 (t+3 at the default).
- A misaligned request acks in cycle t+1.
- Back-to-back requests from one port: minimum request-to-request spacing is WAIT_CYCLES+3 cycles, including one IDLE cycle.
- rdata is valid in the ack cycle and stays stable afterwards.
- cnt width is 4 bits.

## Test plan
- Reset: assert reset_n=0 mid-ACCESS of a store to 0x10 -> all outputs 0 immediately, mem_op never shows OP_SW, memory word 4 unchanged.
- Single load, default: port 0 loads 0x8 with memory[2]=0xDEADBEEF -> mem_op=OP_LW for 2 cycles, ack0 at t+3, rdata0=0xDEADBEEF, rdata1 unchanged.
- Single store, WAIT_CYCLES=3: port 1 stores 0x12345678 to 0x40 -> exactly one cycle of OP_SW at t+4, ack1 at t+5, then a port-0 load of 0x40 returns 0x12345678.
- Simultaneous requests held for 3 transactions -> grant order 0, 1, 0; each ack is a single-cycle pulse to the correct port.
- Misaligned: port 0 load of 0x6 -> ack0 and err0 at t+1, mem_op stays 6'h00.
- WAIT_CYCLES=0: load completes in 2 cycles with one OP_LW cycle; a store gives one OP_SW cycle.
